// File: rtl/mult_div_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  // Operations accepted by the unit; encodings 6 and 7 are unused.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  // Signed ops take operand magnitudes and need a sign correction at the end.
  function automatic logic is_signed_md(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_iter_step.sv
// One iteration of the datapath: either a shift-add multiply step or a
// restoring-divide step, applied to the {hi, lo} working pair.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,     // partial product / partial remainder
  input  logic [WIDTH-1:0] lo_i,     // multiplier bits / dividend-then-quotient bits
  input  logic [WIDTH-1:0] opnd_i,   // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift the whole pair right. Divide: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    // When ge holds the true difference is below 2^WIDTH, so the low bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = ge ? diff : shifted[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU by shift-add, DIV/DIVU by
// restoring division, one bit per cycle, plus single-cycle MTHI/MTLO.
// Handshake: start is only looked at while idle (busy=0); a started op always
// takes WIDTH+2 cycles to done unless flushed or reset; done is a one-cycle pulse.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // Operand magnitudes for signed ops; sign bits are kept for the fixup.
  assign a_sgn = is_signed_md(op) & a[WIDTH-1];
  assign b_sgn = is_signed_md(op) & b[WIDTH-1];
  assign a_mag = a_sgn ? (~a + 1'b1) : a;
  assign b_mag = b_sgn ? (~b + 1'b1) : b;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod + 1'b1;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Next-state and result logic; flush always beats start and in-flight work.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            MD_MTHI: begin hi_d = a; done_d = 1'b1; end
            MD_MTLO: begin lo_d = a; done_d = 1'b1; end
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = S_CALC;
              is_div_d = (op == MD_DIV) || (op == MD_DIVU);
              neg_a_d  = a_sgn;
              neg_b_d  = b_sgn;
              cnt_d    = '0;
              acc_hi_d = '0;
              opnd_d   = is_div_d ? b_mag : a_mag;
              acc_lo_d = is_div_d ? a_mag : b_mag;
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
          end else begin
            // Remainder follows the dividend sign; with a zero divisor it is
            // the dividend itself, so this also restores the raw a.
            hi_d = neg_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
            if (opnd_q == '0) begin
              lo_d  = '1;
              dbz_d = 1'b1;
            end else begin
              lo_d = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        start32 = 1'b0, flush32 = 1'b0;
  md_op_t      op32 = MD_MULTU;
  logic [31:0] a32 = '0, b32 = '0, hi32, lo32;
  logic        busy32, done32, dbz32;

  logic        start8 = 1'b0, flush8 = 1'b0;
  md_op_t      op8 = MD_MULTU;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy8, done8, dbz8;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
    .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];    // {dbz, hi, lo} expected for WIDTH=32
  logic [16:0] exp8_q[$];   // {dbz, hi, lo} expected for WIDTH=8
  logic [31:0] held_hi = '0, held_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch one 32-bit op, optionally pulse a stray MULTU start at cycle glitch,
  // then check latency, hold of hi during busy and the popped result.
  task automatic run32(input md_op_t op, input logic [31:0] av, input logic [31:0] bv,
                       input int glitch, input string nm);
    int cyc;
    logic [64:0] e;
    @(negedge clock);
    start32 = 1'b1; op32 = op; a32 = av; b32 = bv;
    @(posedge clock);
    #1 start32 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) chk({nm, " busy"}, 64'(busy32), 64'd1);
      if (cyc == 5) chk({nm, " hi held"}, 64'(hi32), 64'(held_hi));
      if (glitch != 0 && cyc == glitch) begin
        start32 = 1'b1; op32 = MD_MULTU; a32 = 32'd3; b32 = 32'd3;
      end
      if (glitch != 0 && cyc == glitch + 1) start32 = 1'b0;
    end while (!done32 && cyc < 100);
    chk({nm, " latency"}, 64'(cyc), 64'd34);
    chk({nm, " busy at done"}, 64'(busy32), 64'd0);
    if (exp_q.size() == 0) begin
      chk({nm, " queue empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " hi"}, 64'(hi32), 64'(e[63:32]));
      chk({nm, " lo"}, 64'(lo32), 64'(e[31:0]));
      chk({nm, " dbz"}, 64'(dbz32), 64'(e[64]));
      held_hi = e[63:32];
      held_lo = e[31:0];
    end
    @(negedge clock);
    chk({nm, " done pulse"}, 64'(done32), 64'd0);
  endtask

  task automatic run8(input md_op_t op, input logic [7:0] av, input logic [7:0] bv,
                      input string nm);
    int cyc;
    logic [16:0] e;
    @(negedge clock);
    start8 = 1'b1; op8 = op; a8 = av; b8 = bv;
    @(posedge clock);
    #1 start8 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!done8 && cyc < 100);
    chk({nm, " latency"}, 64'(cyc), 64'd10);
    if (exp8_q.size() == 0) begin
      chk({nm, " queue empty"}, 64'd1, 64'd0);
    end else begin
      e = exp8_q.pop_front();
      chk({nm, " hi"}, 64'(hi8), 64'(e[15:8]));
      chk({nm, " lo"}, 64'(lo8), 64'(e[7:0]));
      chk({nm, " dbz"}, 64'(dbz8), 64'(e[16]));
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    md_op_t      op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          glitch;
  } vec32_t;

  typedef struct {
    md_op_t     op;
    logic [7:0] a, b, hi, lo;
    logic       dbz;
  } vec8_t;

  vec32_t tbl[10];
  vec8_t  tbl8[4];

  initial begin
    int dcnt;
    tbl[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0};
    tbl[1] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0};
    tbl[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0};
    tbl[3] = '{MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 0};
    tbl[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0};
    tbl[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0};
    tbl[6] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 0};
    tbl[7] = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0};
    tbl[8] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0};
    tbl[9] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 5};

    tbl8[0] = '{MD_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0};
    tbl8[1] = '{MD_MULT,  8'hFD, 8'd7,  8'hFF, 8'hEB, 1'b0};
    tbl8[2] = '{MD_DIV,   8'hF9, 8'd2,  8'hFF, 8'hFD, 1'b0};
    tbl8[3] = '{MD_DIVU,  8'd9,  8'd0,  8'd9,  8'hFF, 1'b1};

    // Reset values.
    #1;
    chk("rst hi",   64'(hi32),   64'd0);
    chk("rst lo",   64'(lo32),   64'd0);
    chk("rst busy", 64'(busy32), 64'd0);
    chk("rst done", 64'(done32), 64'd0);
    chk("rst dbz",  64'(dbz32),  64'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;

    // Table-driven mult/div (last entry also carries the ignored stray start).
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({tbl[i].dbz, tbl[i].hi, tbl[i].lo});
      run32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].glitch, $sformatf("v%0d", i));
    end

    // Flush a second op at cycle 10: no done, hi/lo keep 2/14.
    @(negedge clock);
    start32 = 1'b1; op32 = MD_DIVU; a32 = 32'd50; b32 = 32'd3;
    @(posedge clock);
    #1 start32 = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clock);
    chk("flush busy before", 64'(busy32), 64'd1);
    flush32 = 1'b1;
    @(negedge clock);
    flush32 = 1'b0;
    chk("flush busy after", 64'(busy32), 64'd0);
    // start and flush together while idle: flush wins.
    start32 = 1'b1; flush32 = 1'b1; op32 = MD_MULTU; a32 = 32'd5; b32 = 32'd5;
    @(negedge clock);
    start32 = 1'b0; flush32 = 1'b0;
    chk("start+flush busy", 64'(busy32), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done32) dcnt++;
    end
    chk("flush no done", 64'(dcnt), 64'd0);
    chk("flush hi", 64'(hi32), 64'(held_hi));
    chk("flush lo", 64'(lo32), 64'(held_lo));

    // MTHI then MTLO back-to-back.
    start32 = 1'b1; op32 = MD_MTHI; a32 = 32'h1234;
    @(negedge clock);
    chk("mthi done", 64'(done32), 64'd1);
    chk("mthi busy", 64'(busy32), 64'd0);
    chk("mthi hi",   64'(hi32),   64'h1234);
    chk("mthi dbz",  64'(dbz32),  64'd0);
    op32 = MD_MTLO; a32 = 32'hABCD;
    @(negedge clock);
    start32 = 1'b0;
    chk("mtlo done", 64'(done32), 64'd1);
    chk("mtlo busy", 64'(busy32), 64'd0);
    chk("mtlo hi",   64'(hi32),   64'h1234);
    chk("mtlo lo",   64'(lo32),   64'hABCD);
    @(negedge clock);
    chk("mt done drop", 64'(done32), 64'd0);

    // Reset mid-CALC clears everything at once.
    start32 = 1'b1; op32 = MD_MULT; a32 = 32'hFFFFFFFD; b32 = 32'd7;
    @(posedge clock);
    #1 start32 = 1'b0;
    repeat (5) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("arst hi",   64'(hi32),   64'd0);
    chk("arst lo",   64'(lo32),   64'd0);
    chk("arst busy", 64'(busy32), 64'd0);
    chk("arst done", 64'(done32), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    held_hi = '0;
    held_lo = '0;

    // WIDTH=8 reruns.
    for (int i = 0; i < 4; i++) begin
      exp8_q.push_back({tbl8[i].dbz, tbl8[i].hi, tbl8[i].lo});
      run8(tbl8[i].op, tbl8[i].a, tbl8[i].b, $sformatf("w8v%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
